// File: rtl/mat_mac_seq.sv
// mat_mac_seq: sequential N x N matrix ADD/SUB/MUL/MAC engine with a persistent accumulator.
// One inner-product term per cycle for MUL/MAC; operands and results use valid/ready.
module mat_mac_seq #(
  parameter int MAT_SIZE   = 3,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 24
) (
  input  logic                                        clk_i,
  input  logic                                        rst_ni,
  input  logic                                        clr_i,
  input  logic                                        in_valid_i,
  output logic                                        in_ready_o,
  input  logic [1:0]                                  opcode_i,
  input  logic                                        signed_i,
  input  logic [MAT_SIZE*MAT_SIZE*DATA_WIDTH-1:0]     matrixA_i,
  input  logic [MAT_SIZE*MAT_SIZE*DATA_WIDTH-1:0]     matrixB_i,
  output logic                                        out_valid_o,
  input  logic                                        out_ready_i,
  output logic [MAT_SIZE*MAT_SIZE*ACC_WIDTH-1:0]      result_o,
  output logic                                        busy_o
);
  localparam int N  = MAT_SIZE;
  localparam int W  = DATA_WIDTH;
  localparam int AW = ACC_WIDTH;
  localparam int E  = N * N;
  localparam int KW = $clog2(N);
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MAC = 2'b11;

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t            state_q, state_d;
  logic [E*W-1:0]    a_q, a_d, b_q, b_d;
  logic [1:0]        op_q, op_d;
  logic              sgn_q, sgn_d;
  logic [KW-1:0]     k_q, k_d;
  logic [E*AW-1:0]   r_q, r_d, acc_q, acc_d, res_q, res_d, r_step;
  logic              accept, last;

  function automatic logic [W-1:0] el(input logic [E*W-1:0] m, input int i, input int j);
    return m[(E-1-(i*N+j))*W +: W];
  endfunction

  function automatic logic [AW-1:0] ext(input logic [W-1:0] v, input logic s);
    return {{(AW-W){s & v[W-1]}}, v};
  endfunction

  assign accept = state_q == IDLE && in_valid_i && !clr_i;
  assign last   = !op_q[1] || k_q == KW'(N-1);

  // Elementwise ADD/SUB, or one k-term of the matrix product added onto R
  always_comb begin
    r_step = r_q;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        r_step[(E-1-(i*N+j))*AW +: AW] =
          op_q == OP_ADD ? ext(el(a_q, i, j), sgn_q) + ext(el(b_q, i, j), sgn_q) :
          op_q == OP_SUB ? ext(el(a_q, i, j), sgn_q) - ext(el(b_q, i, j), sgn_q) :
          r_q[(E-1-(i*N+j))*AW +: AW] +
            ext(el(a_q, i, int'(k_q)), sgn_q) * ext(el(b_q, int'(k_q), j), sgn_q);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? COMPUTE : IDLE;
      COMPUTE: state_d = clr_i ? IDLE : last ? DONE : COMPUTE;
      DONE:    state_d = clr_i || out_ready_i ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready_o  = state_q == IDLE && !clr_i;
    out_valid_o = state_q == DONE;
    busy_o      = state_q != IDLE;
    result_o    = res_q;
  end

  always_comb begin
    a_d   = accept ? matrixA_i : a_q;
    b_d   = accept ? matrixB_i : b_q;
    op_d  = accept ? opcode_i : op_q;
    sgn_d = accept ? signed_i : sgn_q;
    k_d   = k_q;
    r_d   = r_q;
    res_d = res_q;
    acc_d = clr_i ? '0 : acc_q;
    if (accept) begin
      k_d = '0;
      r_d = opcode_i == OP_MAC ? acc_q : '0;
    end
    if (state_q == COMPUTE && !clr_i) begin
      r_d   = r_step;
      k_d   = last ? k_q : k_q + 1'b1;
      res_d = last ? r_step : res_q;
    end
    // Accumulator commits only when a MAC result is actually taken
    if (state_q == DONE && !clr_i && out_ready_i && op_q == OP_MAC) acc_d = r_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      sgn_q <= 1'b0;
      k_q   <= '0;
      r_q   <= '0;
      acc_q <= '0;
      res_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      op_q  <= op_d;
      sgn_q <= sgn_d;
      k_q   <= k_d;
      r_q   <= r_d;
      acc_q <= acc_d;
      res_q <= res_d;
    end
  end
endmodule

// File: tb/tb_mat_mac_seq.sv
// tb_mat_mac_seq: randomized and directed checks of mat_mac_seq against a matrix-level model.
module tb_mat_mac_seq;
  localparam int N = 3, W = 8, AW = 24, E = 9;
  typedef int m9_t [9];

  logic clk_i = 0, rst_ni = 0, clr_i = 0, in_valid_i = 0, signed_i = 0, out_ready_i = 1;
  logic in_ready_o, out_valid_o, busy_o;
  logic [1:0] opcode_i = 0;
  logic [E*W-1:0] matrixA_i = '0, matrixB_i = '0;
  logic [E*AW-1:0] result_o;

  int n_chk = 0, n_fail = 0;
  logic [E*AW-1:0] exp_r = '0, macc = '0, res = '0;
  bit exp_pending = 0;

  always #5 clk_i = ~clk_i;

  mat_mac_seq #(.MAT_SIZE(N), .DATA_WIDTH(W), .ACC_WIDTH(AW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clr_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .opcode_i(opcode_i), .signed_i(signed_i),
    .matrixA_i(matrixA_i), .matrixB_i(matrixB_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .result_o(result_o), .busy_o(busy_o)
  );

  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", n, got, exp);
    end
  endtask

  task automatic chkv(input string n, input logic [E*AW-1:0] got, input logic [E*AW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask

  function automatic logic [W-1:0] el(input logic [E*W-1:0] m, input int i, input int j);
    return m[(E-1-(i*N+j))*W +: W];
  endfunction

  function automatic longint xt(input logic [W-1:0] v, input bit s);
    return s ? longint'($signed(v)) : longint'(v);
  endfunction

  function automatic logic [E*AW-1:0] model(input logic [1:0] op, input bit s,
                                            input logic [E*W-1:0] a, input logic [E*W-1:0] b);
    logic [E*AW-1:0] r;
    longint v;
    logic [63:0] t;
    r = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        if (op == 2'd0) v = xt(el(a, i, j), s) + xt(el(b, i, j), s);
        else if (op == 2'd1) v = xt(el(a, i, j), s) - xt(el(b, i, j), s);
        else begin
          v = (op == 2'd3) ? longint'(macc[(E-1-(i*N+j))*AW +: AW]) : 0;
          for (int k = 0; k < N; k++) v += xt(el(a, i, k), s) * xt(el(b, k, j), s);
        end
        t = v;
        r[(E-1-(i*N+j))*AW +: AW] = t[AW-1:0];
      end
    return r;
  endfunction

  function automatic logic [E*W-1:0] pk8(input m9_t v);
    logic [E*W-1:0] r;
    for (int p = 0; p < E; p++) r[(E-1-p)*W +: W] = v[p][W-1:0];
    return r;
  endfunction

  function automatic logic [E*AW-1:0] pk24(input m9_t v);
    logic [E*AW-1:0] r;
    for (int p = 0; p < E; p++) r[(E-1-p)*AW +: AW] = v[p][AW-1:0];
    return r;
  endfunction

  function automatic logic [E*W-1:0] rnd72();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[E*W-1:0];
  endfunction

  // Every cycle a result is presented it must equal the model's pending result
  always @(negedge clk_i) begin
    if (rst_ni && out_valid_o) begin
      chk("valid_expected", 64'(exp_pending), 64'd1);
      chkv("result", result_o, exp_r);
      chk("in_ready_in_done", 64'(in_ready_o), 64'd0);
      chk("busy_in_done", 64'(busy_o), 64'd1);
    end
  end

  // mode: 0 normal, 1 clr at k=1, 2 clr in DONE with out_ready high, 3 reset mid-operation
  task automatic run_op(input logic [1:0] op, input bit sg, input logic [E*W-1:0] a,
                        input logic [E*W-1:0] b, input int stall, input int mode);
    int t, lat;
    t = 0;
    while (!in_ready_o && t < 50) begin @(negedge clk_i); t++; end
    chk("ready_before_op", 64'(in_ready_o), 64'd1);
    opcode_i = op; signed_i = sg; matrixA_i = a; matrixB_i = b;
    in_valid_i = 1; out_ready_i = (stall == 0);
    @(posedge clk_i); #1;
    in_valid_i = 0; matrixA_i = rnd72(); matrixB_i = rnd72();
    opcode_i = 2'($urandom()); signed_i = 1'($urandom());
    exp_r = model(op, sg, a, b);
    exp_pending = 1;
    if (mode == 1) begin
      @(posedge clk_i); #1 clr_i = 1;
      @(posedge clk_i); #1 clr_i = 0;
      exp_pending = 0; macc = '0;
      @(negedge clk_i);
      chk("abort_no_valid", 64'(out_valid_o), 64'd0);
      chk("abort_idle", 64'(busy_o), 64'd0);
      chk("abort_ready", 64'(in_ready_o), 64'd1);
      return;
    end
    if (mode == 3) begin
      @(posedge clk_i); #1 rst_ni = 0;
      exp_pending = 0; macc = '0;
      #1;
      chk("rst_valid", 64'(out_valid_o), 64'd0);
      chk("rst_busy", 64'(busy_o), 64'd0);
      chkv("rst_result", result_o, '0);
      chk("rst_ready", 64'(in_ready_o), 64'd1);
      @(negedge clk_i); rst_ni = 1;
      @(negedge clk_i);
      return;
    end
    lat = 0;
    do begin
      @(posedge clk_i); lat++;
      @(negedge clk_i);
    end while (!out_valid_o && lat < 20);
    chk("latency", 64'(lat), op[1] ? 64'(N) : 64'd1);
    if (!out_valid_o) begin exp_pending = 0; return; end
    res = result_o;
    repeat (stall) begin
      in_valid_i = 1; matrixA_i = rnd72();
      @(negedge clk_i);
      chkv("held_result", result_o, res);
    end
    in_valid_i = 0;
    if (mode == 2) begin
      clr_i = 1; out_ready_i = 1;
      @(posedge clk_i); #1 clr_i = 0;
      exp_pending = 0; macc = '0;
      @(negedge clk_i);
      chk("done_clr_valid", 64'(out_valid_o), 64'd0);
      return;
    end
    out_ready_i = 1;
    @(posedge clk_i); #1;
    if (op == 2'd3) macc = exp_r;
    exp_pending = 0;
    @(negedge clk_i);
    chk("post_valid", 64'(out_valid_o), 64'd0);
    chk("post_ready", 64'(in_ready_o), 64'd1);
  endtask

  task automatic lit(input string n, input m9_t v);
    chkv(n, res, pk24(v));
    chkv({n, "_model"}, exp_r, pk24(v));
  endtask

  initial begin
    logic [E*W-1:0] t3, ff;
    m9_t ta, prod, dbl, zer, ffs, ffu, ffa;
    ta   = '{1, 2, 3, 5, 4, 3, 1, 0, 1};
    prod = '{14, 10, 12, 28, 26, 30, 2, 2, 4};
    dbl  = '{28, 20, 24, 56, 52, 60, 4, 4, 8};
    zer  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    ffs  = '{3, 3, 3, 3, 3, 3, 3, 3, 3};
    ffu  = '{195075, 195075, 195075, 195075, 195075, 195075, 195075, 195075, 195075};
    ffa  = '{255, 255, 255, 255, 255, 255, 255, 255, 255};
    t3 = pk8(ta);
    ff = pk8(ffa);
    for (int p = 0; p < E; p++) ffa[p] = 24'hFFFFFE;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("reset_valid", 64'(out_valid_o), 64'd0);
    chk("reset_busy", 64'(busy_o), 64'd0);
    chkv("reset_result", result_o, '0);
    chk("reset_ready", 64'(in_ready_o), 64'd1);
    rst_ni = 1;
    @(negedge clk_i);

    run_op(2'd0, 0, t3, t3, 0, 0); lit("add", '{2, 4, 6, 10, 8, 6, 2, 0, 2});
    run_op(2'd1, 0, t3, t3, 0, 0); lit("sub", zer);
    run_op(2'd2, 0, t3, t3, 0, 0); lit("mul", prod);
    run_op(2'd3, 0, t3, t3, 0, 0); lit("mac1", prod);
    run_op(2'd3, 0, t3, t3, 0, 0); lit("mac2", dbl);
    clr_i = 1; @(posedge clk_i); #1 clr_i = 0; macc = '0; @(negedge clk_i);
    run_op(2'd3, 0, t3, t3, 0, 0); lit("mac_after_clr", prod);

    run_op(2'd2, 1, ff, ff, 0, 0); lit("mul_ff_signed", ffs);
    run_op(2'd2, 0, ff, ff, 0, 0); lit("mul_ff_unsigned", ffu);
    run_op(2'd0, 1, ff, ff, 0, 0); lit("add_ff_signed", ffa);

    run_op(2'd0, 0, t3, t3, 5, 0); lit("backpressure", '{2, 4, 6, 10, 8, 6, 2, 0, 2});

    run_op(2'd2, 0, t3, t3, 0, 1);
    run_op(2'd3, 0, t3, t3, 0, 0); lit("mac_after_abort", prod);

    clr_i = 1; in_valid_i = 1; opcode_i = 2'd2; #1;
    chk("clr_blocks_ready", 64'(in_ready_o), 64'd0);
    @(posedge clk_i); #1 clr_i = 0; in_valid_i = 0; macc = '0;
    @(negedge clk_i);
    chk("clr_not_accepted", 64'(busy_o), 64'd0);
    run_op(2'd3, 0, t3, t3, 0, 0); lit("mac_after_idle_clr", prod);

    run_op(2'd3, 0, t3, t3, 2, 2);
    run_op(2'd3, 0, t3, t3, 0, 0); lit("mac_after_done_clr", prod);

    run_op(2'd3, 0, t3, t3, 0, 3);
    run_op(2'd3, 0, t3, t3, 0, 0); lit("mac_after_reset", prod);

    for (int n = 0; n < 40; n++)
      run_op(2'($urandom_range(0, 3)), 1'($urandom()), rnd72(), rnd72(), $urandom_range(0, 3), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
